// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle controller: states, ALU codes, datapath select codes, opcodes.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC_R = 4'd6,
      S_RWB    = 4'd7,
      S_BRANCH = 4'd8,
      S_EXEC_I = 4'd9,
      S_IWB    = 4'd10,
      S_JUMP   = 4'd11,
      S_JREG   = 4'd12
   } state_t;

   // Which ALU decode the current state needs
   typedef enum logic [2:0] {
      EX_NONE  = 3'd0,
      EX_ADDR  = 3'd1,
      EX_SUB   = 3'd2,
      EX_RTYPE = 3'd3,
      EX_ITYPE = 3'd4
   } exec_t;

   localparam logic [3:0] ALU_ADD     = 4'd0;
   localparam logic [3:0] ALU_SUB     = 4'd1;
   localparam logic [3:0] ALU_AND     = 4'd2;
   localparam logic [3:0] ALU_OR      = 4'd3;
   localparam logic [3:0] ALU_NOR     = 4'd4;
   localparam logic [3:0] ALU_SLT     = 4'd5;
   localparam logic [3:0] ALU_SLTU    = 4'd6;
   localparam logic [3:0] ALU_SHIFTL  = 4'd7;
   localparam logic [3:0] ALU_SHIFTR  = 4'd8;
   localparam logic [3:0] ALU_SHIFTLV = 4'd9;
   localparam logic [3:0] ALU_SHIFTRV = 4'd10;
   localparam logic [3:0] ALU_SHIFT16 = 4'd11;

   localparam logic [1:0] SRCB_B    = 2'b00;
   localparam logic [1:0] SRCB_4    = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;
   localparam logic [1:0] SRCB_BOFS = 2'b11;

   localparam logic [1:0] RDST_RT = 2'b00;
   localparam logic [1:0] RDST_RD = 2'b01;
   localparam logic [1:0] RDST_RA = 2'b10;

   localparam logic [1:0] M2R_ALU = 2'b00;
   localparam logic [1:0] M2R_MDR = 2'b01;
   localparam logic [1:0] M2R_PC  = 2'b10;

   localparam logic [1:0] PCS_ALU    = 2'b00;
   localparam logic [1:0] PCS_ALUOUT = 2'b01;
   localparam logic [1:0] PCS_JUMP   = 2'b10;
   localparam logic [1:0] PCS_REG    = 2'b11;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_JALR = 6'h09;

   // R-type functions executed through EXEC_R
   function automatic logic r_funct_ok(input logic [5:0] f);
      case (f)
         6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27,
         6'h2A, 6'h2B, 6'h00, 6'h02, 6'h04, 6'h06: r_funct_ok = 1'b1;
         default:                                   r_funct_ok = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mc_ctrl_aludec.sv
// Combinational ALU decode: maps Op/Funct and the state's exec type onto ALUOp and EXTOp.
module mc_aludec
   import mc_ctrl_pkg::*;
(
   input  logic [5:0] i_op,
   input  logic [5:0] i_funct,
   input  exec_t      i_exec,
   output logic [3:0] o_aluop,
   output logic       o_extop
);

   always_comb begin
      o_aluop = ALU_ADD;
      o_extop = 1'b0;
      case (i_exec)
         EX_ADDR: o_extop = 1'b1;
         EX_SUB:  o_aluop = ALU_SUB;
         EX_RTYPE: begin
            case (i_funct)
               6'h22, 6'h23: o_aluop = ALU_SUB;
               6'h24:        o_aluop = ALU_AND;
               6'h25:        o_aluop = ALU_OR;
               6'h27:        o_aluop = ALU_NOR;
               6'h2A:        o_aluop = ALU_SLT;
               6'h2B:        o_aluop = ALU_SLTU;
               6'h00:        o_aluop = ALU_SHIFTL;
               6'h02:        o_aluop = ALU_SHIFTR;
               6'h04:        o_aluop = ALU_SHIFTLV;
               6'h06:        o_aluop = ALU_SHIFTRV;
               default:      o_aluop = ALU_ADD;
            endcase
         end
         EX_ITYPE: begin
            // Only the arithmetic immediates are sign-extended
            case (i_op)
               OP_ADDI, OP_ADDIU: o_extop = 1'b1;
               OP_SLTI: begin
                  o_aluop = ALU_SLT;
                  o_extop = 1'b1;
               end
               OP_ANDI: o_aluop = ALU_AND;
               OP_ORI:  o_aluop = ALU_OR;
               OP_LUI:  o_aluop = ALU_SHIFT16;
               default: o_aluop = ALU_ADD;
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle MIPS main controller: sequences fetch/decode/execute/memory/writeback, drives datapath controls.
// Define MCTRL_JREG_EN to build the JREG state for jr/jalr; otherwise those encodings decode as illegal.
module mc_ctrl
   import mc_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] Op,
   input  logic [5:0] Funct,
   input  logic       Zero,
   output logic       PCWrite,
   output logic       IRWrite,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic       IorD,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [3:0] ALUOp,
   output logic       EXTOp,
   output logic [1:0] RegDst,
   output logic [1:0] MemtoReg,
   output logic [1:0] PCSource,
   output logic       Illegal,
   output logic [3:0] State
);

   state_t r_state;
   state_t w_st;
   exec_t  w_exec;
   logic   w_dec_illegal;
   logic   w_pcw, w_irw, w_memw, w_regw, w_ill;

   always_comb begin
      w_dec_illegal = 1'b0;
      case (Op)
         OP_RTYPE: begin
            if (Funct == FN_JR || Funct == FN_JALR) begin
`ifdef MCTRL_JREG_EN
               w_dec_illegal = 1'b0;
`else
               w_dec_illegal = 1'b1;
`endif
            end else begin
               w_dec_illegal = !r_funct_ok(Funct);
            end
         end
         OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL,
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: w_dec_illegal = 1'b0;
         default: w_dec_illegal = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_FETCH;
      end else begin
         case (r_state)
            S_FETCH: r_state <= S_DECODE;
            S_DECODE: begin
               if (w_dec_illegal) begin
                  r_state <= S_FETCH;
               end else begin
                  case (Op)
                     OP_LW, OP_SW:   r_state <= S_MEMADR;
`ifdef MCTRL_JREG_EN
                     OP_RTYPE:       r_state <= (Funct == FN_JR || Funct == FN_JALR) ? S_JREG : S_EXEC_R;
`else
                     OP_RTYPE:       r_state <= S_EXEC_R;
`endif
                     OP_BEQ, OP_BNE: r_state <= S_BRANCH;
                     OP_J, OP_JAL:   r_state <= S_JUMP;
                     default:        r_state <= S_EXEC_I;
                  endcase
               end
            end
            S_MEMADR: r_state <= (Op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  r_state <= S_MEMWB;
            S_EXEC_R: r_state <= S_RWB;
            S_EXEC_I: r_state <= S_IWB;
            default:  r_state <= S_FETCH;
         endcase
      end
   end

   // Under reset the outputs look like FETCH, with the side-effecting strobes suppressed below
   assign w_st  = rst ? S_FETCH : r_state;
   assign State = r_state;

   always_comb begin
      case (w_st)
         S_DECODE, S_MEMADR: w_exec = EX_ADDR;
         S_EXEC_R:           w_exec = EX_RTYPE;
         S_BRANCH:           w_exec = EX_SUB;
         S_EXEC_I:           w_exec = EX_ITYPE;
         default:            w_exec = EX_NONE;
      endcase
   end

   mc_aludec u_aludec (
      .i_op    (Op),
      .i_funct (Funct),
      .i_exec  (w_exec),
      .o_aluop (ALUOp),
      .o_extop (EXTOp)
   );

   always_comb begin
      w_pcw    = 1'b0;
      w_irw    = 1'b0;
      w_memw   = 1'b0;
      w_regw   = 1'b0;
      w_ill    = 1'b0;
      IorD     = 1'b0;
      ALUSrcA  = 1'b0;
      ALUSrcB  = SRCB_B;
      RegDst   = RDST_RT;
      MemtoReg = M2R_ALU;
      PCSource = PCS_ALU;
      case (w_st)
         S_FETCH: begin
            w_irw   = 1'b1;
            w_pcw   = 1'b1;
            ALUSrcB = SRCB_4;
         end
         S_DECODE: begin
            ALUSrcB = SRCB_BOFS;
            w_ill   = w_dec_illegal;
         end
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
         end
         S_MEMRD: IorD = 1'b1;
         S_MEMWB: begin
            w_regw   = 1'b1;
            MemtoReg = M2R_MDR;
         end
         S_MEMWR: begin
            IorD   = 1'b1;
            w_memw = 1'b1;
         end
         S_EXEC_R: ALUSrcA = 1'b1;
         S_RWB: begin
            w_regw = 1'b1;
            RegDst = RDST_RD;
         end
         S_BRANCH: begin
            ALUSrcA  = 1'b1;
            PCSource = PCS_ALUOUT;
            w_pcw    = (Op == OP_BNE) ? !Zero : Zero;
         end
         S_EXEC_I: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
         end
         S_IWB: w_regw = 1'b1;
         S_JUMP: begin
            PCSource = PCS_JUMP;
            w_pcw    = 1'b1;
            if (Op == OP_JAL) begin
               w_regw   = 1'b1;
               RegDst   = RDST_RA;
               MemtoReg = M2R_PC;
            end
         end
`ifdef MCTRL_JREG_EN
         S_JREG: begin
            PCSource = PCS_REG;
            w_pcw    = 1'b1;
            if (Funct == FN_JALR) begin
               w_regw   = 1'b1;
               RegDst   = RDST_RD;
               MemtoReg = M2R_PC;
            end
         end
`endif
         default: ;
      endcase
   end

   assign PCWrite  = w_pcw  & !rst;
   assign IRWrite  = w_irw  & !rst;
   assign MemWrite = w_memw & !rst;
   assign RegWrite = w_regw & !rst;
   assign Illegal  = w_ill  & !rst;

endmodule
